// File: rtl/iommu_responder_pkg.sv
// Shared types and constants for the IOMMU responder: state encoding, PTE layout,
// TLB entry format and the page-table address helper.
package iommu_pkg;

  localparam int PAGE_SHIFT = 12;
  localparam int VPN_W      = 32 - PAGE_SHIFT;
  localparam int PTE_V      = 0;
  localparam int PTE_W      = 1;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WALK,
    RESP,
    SETTLE,
    ACCESS,
    MEM_WAIT
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [VPN_W-1:0] vpn;
    logic [VPN_W-1:0] ppn;
    logic             w;
  } tlb_entry_t;

  // One 32-bit PTE per VPN; the sum wraps at 32 bits.
  function automatic logic [31:0] pte_addr(input logic [31:0] base, input logic [VPN_W-1:0] vpn);
    return base + {{(32-VPN_W-2){1'b0}}, vpn, 2'b00};
  endfunction

endpackage

// File: rtl/iommu_responder_if.sv
// DMA-side translate/access bus and the shared memory port used by the responder.
interface iommu_dma_if;
  logic [31:0] iommu_daddr;
  logic        iommu_translate_request;
  logic        iommu_write_en;
  logic [31:0] iommu_write_data;
  logic [31:0] iommu_paddr;
  logic [31:0] iommu_data_out;
  logic        iommu_translation_done;
  logic        iommu_fault;

  modport master (
    output iommu_daddr, iommu_translate_request, iommu_write_en, iommu_write_data,
    input  iommu_paddr, iommu_data_out, iommu_translation_done, iommu_fault
  );
  modport slave (
    input  iommu_daddr, iommu_translate_request, iommu_write_en, iommu_write_data,
    output iommu_paddr, iommu_data_out, iommu_translation_done, iommu_fault
  );
endinterface

interface iommu_mem_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/iommu_tlb.sv
// Fully-associative TLB: combinational CAM lookup, round-robin install, flush.
module iommu_tlb
  import iommu_pkg::*;
#(
  parameter int TLB_ENTRIES = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [VPN_W-1:0] lookup_vpn,
  output logic             hit,
  output logic [VPN_W-1:0] hit_ppn,
  output logic             hit_w,
  input  logic             install_en,
  input  logic [VPN_W-1:0] install_vpn,
  input  logic [VPN_W-1:0] install_ppn,
  input  logic             install_w,
  input  logic             flush
);

  localparam int IDX_W = $clog2(TLB_ENTRIES);

  tlb_entry_t       r_entries [TLB_ENTRIES];
  logic [IDX_W-1:0] r_ptr;

  // Flush takes priority over a same-edge install.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TLB_ENTRIES; i++) r_entries[i] <= '0;
      r_ptr <= '0;
    end else if (flush) begin
      for (int i = 0; i < TLB_ENTRIES; i++) r_entries[i].valid <= 1'b0;
      r_ptr <= '0;
    end else if (install_en) begin
      r_entries[r_ptr] <= '{valid: 1'b1, vpn: install_vpn, ppn: install_ppn, w: install_w};
      r_ptr            <= r_ptr + IDX_W'(1);
    end
  end

  // Entries never share a VPN, so OR-combining the matching entries is exact.
  always_comb begin
    hit     = 1'b0;
    hit_ppn = '0;
    hit_w   = 1'b0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (r_entries[i].valid && (r_entries[i].vpn == lookup_vpn)) begin
        hit     = 1'b1;
        hit_ppn = hit_ppn | r_entries[i].ppn;
        hit_w   = hit_w | r_entries[i].w;
      end
    end
  end

endmodule

// File: rtl/iommu_responder.sv
// IOMMU responder: translates DMA virtual addresses through a TLB / single-level
// page walk, then performs the follow-on data access on the shared memory port.
//
//   state    | meaning
//   IDLE     | wait for translate request, latch address
//   LOOKUP   | bypass / TLB hit / start PTE read
//   WALK     | wait for PTE read ack
//   RESP     | report translation (done pulse next cycle)
//   SETTLE   | one gap cycle for the DMA to set write_en
//   ACCESS   | sample write_en/data, check permission, start access
//   MEM_WAIT | wait for data access ack
module iommu_responder
  import iommu_pkg::*;
#(
  parameter int TLB_ENTRIES = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  iommu_dma_if.slave  dma,
  iommu_mem_if.master mem,
  input  logic [31:0] cfg_pt_base,
  input  logic        cfg_enable,
  input  logic        tlb_flush,
  output logic [15:0] stat_misses
);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_vaddr, r_paddr;
  logic        r_w, r_fault;
  logic [31:0] r_paddr_o, r_data_out;
  logic        r_done, r_fault_o;
  logic        r_mem_req, r_mem_we;
  logic [31:0] r_mem_addr, r_mem_wdata;
  logic [15:0] r_misses;

  logic             w_hit, w_hit_w, w_install, w_wr_denied;
  logic [VPN_W-1:0] w_hit_ppn;

  iommu_tlb #(.TLB_ENTRIES(TLB_ENTRIES)) u_tlb (
    .clk         (clk),
    .reset_n     (reset_n),
    .lookup_vpn  (r_vaddr[31:PAGE_SHIFT]),
    .hit         (w_hit),
    .hit_ppn     (w_hit_ppn),
    .hit_w       (w_hit_w),
    .install_en  (w_install),
    .install_vpn (r_vaddr[31:PAGE_SHIFT]),
    .install_ppn (mem.mem_rdata[31:PAGE_SHIFT]),
    .install_w   (mem.mem_rdata[PTE_W]),
    .flush       (tlb_flush)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_install   = 1'b0;
    w_wr_denied = dma.iommu_write_en && !r_w;
    case (r_state)
      IDLE:     if (dma.iommu_translate_request) w_state_nxt = LOOKUP;
      LOOKUP:   w_state_nxt = (!cfg_enable || w_hit) ? RESP : WALK;
      WALK: begin
        if (mem.mem_ack) begin
          w_install   = mem.mem_rdata[PTE_V];
          w_state_nxt = RESP;
        end
      end
      RESP:     w_state_nxt = r_fault ? IDLE : SETTLE;
      SETTLE:   w_state_nxt = ACCESS;
      ACCESS:   w_state_nxt = w_wr_denied ? IDLE : MEM_WAIT;
      MEM_WAIT: if (mem.mem_ack) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vaddr     <= '0;
      r_paddr     <= '0;
      r_w         <= 1'b0;
      r_fault     <= 1'b0;
      r_paddr_o   <= '0;
      r_data_out  <= '0;
      r_done      <= 1'b0;
      r_fault_o   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_misses    <= '0;
    end else begin
      r_done    <= 1'b0;
      r_fault_o <= 1'b0;
      case (r_state)
        IDLE: if (dma.iommu_translate_request) r_vaddr <= dma.iommu_daddr;
        LOOKUP: begin
          r_fault <= 1'b0;
          if (!cfg_enable) begin
            r_paddr <= r_vaddr;
            r_w     <= 1'b1;
          end else if (w_hit) begin
            r_paddr <= {w_hit_ppn, r_vaddr[PAGE_SHIFT-1:0]};
            r_w     <= w_hit_w;
          end else begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= pte_addr(cfg_pt_base, r_vaddr[31:PAGE_SHIFT]);
            if (r_misses != 16'hFFFF) r_misses <= r_misses + 16'd1;
          end
        end
        WALK: begin
          if (mem.mem_ack) begin
            r_mem_req <= 1'b0;
            if (mem.mem_rdata[PTE_V]) begin
              r_paddr <= {mem.mem_rdata[31:PAGE_SHIFT], r_vaddr[PAGE_SHIFT-1:0]};
              r_w     <= mem.mem_rdata[PTE_W];
            end else begin
              r_fault <= 1'b1;
            end
          end
        end
        RESP: begin
          r_done    <= 1'b1;
          r_fault_o <= r_fault;
          r_paddr_o <= r_fault ? 32'h0 : r_paddr;
        end
        ACCESS: begin
          if (w_wr_denied) begin
            r_done    <= 1'b1;
            r_fault_o <= 1'b1;
          end else begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= dma.iommu_write_en;
            r_mem_addr  <= r_paddr;
            r_mem_wdata <= dma.iommu_write_data;
          end
        end
        MEM_WAIT: begin
          if (mem.mem_ack) begin
            r_mem_req <= 1'b0;
            r_done    <= 1'b1;
            if (!r_mem_we) r_data_out <= mem.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign dma.iommu_paddr            = r_paddr_o;
  assign dma.iommu_data_out         = r_data_out;
  assign dma.iommu_translation_done = r_done;
  assign dma.iommu_fault            = r_fault_o;
  assign mem.mem_req                = r_mem_req;
  assign mem.mem_we                 = r_mem_we;
  assign mem.mem_addr               = r_mem_addr;
  assign mem.mem_wdata              = r_mem_wdata;
  assign stat_misses                = r_misses;

endmodule

// File: tb/tb_iommu_responder.sv
// Directed bench for iommu_responder with a one-cycle-ack memory model.
module tb_iommu_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] cfg_pt_base = 32'h0;
  logic        cfg_enable = 1'b0;
  logic        tlb_flush = 1'b0;
  logic [15:0] stat_misses;

  iommu_dma_if dma();
  iommu_mem_if mem();

  iommu_responder #(.TLB_ENTRIES(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .dma         (dma),
    .mem         (mem),
    .cfg_pt_base (cfg_pt_base),
    .cfg_enable  (cfg_enable),
    .tlb_flush   (tlb_flush),
    .stat_misses (stat_misses)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_model [logic [31:0]];
  logic        mem_stall = 1'b0;
  int          n_txn = 0;
  int          n_wr = 0;
  logic [31:0] last_addr = 32'h0;
  int          exp_misses = 0;

  // Memory acks one cycle after seeing a request.
  always @(negedge clk) begin
    if (mem.mem_ack) begin
      mem.mem_ack = 1'b0;
    end else if (mem.mem_req && !mem_stall && reset_n) begin
      mem.mem_ack = 1'b1;
      n_txn++;
      last_addr = mem.mem_addr;
      if (mem.mem_we) begin
        n_wr++;
        mem_model[mem.mem_addr] = mem.mem_wdata;
      end else begin
        mem.mem_rdata = mem_model.exists(mem.mem_addr) ? mem_model[mem.mem_addr] : 32'h0;
      end
    end
  end

  task automatic translate(input logic [31:0] a, output int lat, output logic [31:0] pa,
                           output logic flt);
    lat = -1; pa = 32'hX; flt = 1'bX;
    @(negedge clk);
    dma.iommu_daddr = a;
    dma.iommu_translate_request = 1'b1;
    @(posedge clk);
    #1 dma.iommu_translate_request = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (dma.iommu_translation_done) begin
        lat = i; pa = dma.iommu_paddr; flt = dma.iommu_fault;
        break;
      end
    end
  endtask

  // Called right after the translation done pulse has been observed.
  task automatic access(input logic we, input logic [31:0] wd, output logic got,
                        output logic [31:0] rd, output logic flt);
    got = 1'b0; rd = 32'hX; flt = 1'bX;
    dma.iommu_write_en = we;
    dma.iommu_write_data = wd;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (dma.iommu_translation_done) begin
        got = 1'b1; rd = dma.iommu_data_out; flt = dma.iommu_fault;
        break;
      end
    end
    dma.iommu_write_en = 1'b0;
  endtask

  task automatic flush_tlb();
    @(negedge clk) tlb_flush = 1'b1;
    @(negedge clk) tlb_flush = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (dma.iommu_paddr !== 32'h0 || dma.iommu_data_out !== 32'h0) begin
      errors++; $display("FAIL reset_data: paddr %h data %h, want 0", dma.iommu_paddr, dma.iommu_data_out);
    end
    checks++;
    if (dma.iommu_translation_done !== 1'b0 || dma.iommu_fault !== 1'b0 || mem.mem_req !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: done %b fault %b req %b, want 0", dma.iommu_translation_done, dma.iommu_fault, mem.mem_req);
    end
    checks++;
    if (stat_misses !== 16'h0) begin
      errors++; $display("FAIL reset_misses: got %h want 0", stat_misses);
    end
  endtask

  task automatic test_bypass();
    int lat; logic [31:0] pa, rd; logic flt, got;
    cfg_enable = 1'b0;
    mem_model[32'h0000_1234] = 32'hDEAD_BEEF;
    translate(32'h0000_1234, lat, pa, flt);
    checks++;
    if (lat !== 2 || pa !== 32'h0000_1234 || flt !== 1'b0) begin
      errors++; $display("FAIL bypass_xlate: lat %0d paddr %h fault %b, want 2 00001234 0", lat, pa, flt);
    end
    access(1'b0, 32'h0, got, rd, flt);
    checks++;
    if (got !== 1'b1 || rd !== 32'hDEAD_BEEF || flt !== 1'b0 || last_addr !== 32'h0000_1234) begin
      errors++; $display("FAIL bypass_read: done %b data %h fault %b addr %h, want 1 deadbeef 0 00001234", got, rd, flt, last_addr);
    end
  endtask

  task automatic test_miss_hit();
    int lat, txn0; logic [31:0] pa, rd; logic flt, got;
    cfg_enable = 1'b1;
    cfg_pt_base = 32'h0000_8000;
    mem_model[32'h0000_800C] = 32'h0005_0003;
    mem_model[32'h0005_0010] = 32'hCAFE_0001;
    translate(32'h0000_3010, lat, pa, flt);
    exp_misses++;
    checks++;
    if (lat !== 3 || pa !== 32'h0005_0010 || flt !== 1'b0 || last_addr !== 32'h0000_800C) begin
      errors++; $display("FAIL miss_xlate: lat %0d paddr %h fault %b walk %h, want 3 00050010 0 0000800c", lat, pa, flt, last_addr);
    end
    checks++;
    if (stat_misses !== 16'(exp_misses)) begin
      errors++; $display("FAIL miss_count: got %0d want %0d", stat_misses, exp_misses);
    end
    access(1'b0, 32'h0, got, rd, flt);
    checks++;
    if (got !== 1'b1 || rd !== 32'hCAFE_0001 || flt !== 1'b0) begin
      errors++; $display("FAIL miss_read: done %b data %h fault %b, want 1 cafe0001 0", got, rd, flt);
    end
    txn0 = n_txn;
    translate(32'h0000_3020, lat, pa, flt);
    checks++;
    if (lat !== 2 || pa !== 32'h0005_0020 || flt !== 1'b0 || n_txn !== txn0) begin
      errors++; $display("FAIL hit_xlate: lat %0d paddr %h fault %b memtxn %0d, want 2 00050020 0 %0d", lat, pa, flt, n_txn, txn0);
    end
    access(1'b1, 32'h1122_3344, got, rd, flt);
    checks++;
    if (got !== 1'b1 || flt !== 1'b0 || mem_model[32'h0005_0020] !== 32'h1122_3344) begin
      errors++; $display("FAIL hit_write: done %b fault %b mem %h, want 1 0 11223344", got, flt, mem_model[32'h0005_0020]);
    end
  endtask

  task automatic test_invalid_pte();
    int lat, txn0; logic [31:0] pa; logic flt; logic quiet;
    mem_model[32'h0000_801C] = 32'h0000_0000;
    translate(32'h0000_7004, lat, pa, flt);
    exp_misses++;
    checks++;
    if (lat !== 3 || pa !== 32'h0 || flt !== 1'b1) begin
      errors++; $display("FAIL inv_pte: lat %0d paddr %h fault %b, want 3 0 1", lat, pa, flt);
    end
    txn0 = n_txn;
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (dma.iommu_translation_done || mem.mem_req) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1 || n_txn !== txn0) begin
      errors++; $display("FAIL inv_idle: quiet %b memtxn %0d, want 1 %0d", quiet, n_txn, txn0);
    end
    translate(32'h0000_3040, lat, pa, flt);
    checks++;
    if (lat !== 2 || pa !== 32'h0005_0040 || stat_misses !== 16'(exp_misses)) begin
      errors++; $display("FAIL inv_tlb_kept: lat %0d paddr %h misses %0d, want 2 00050040 %0d", lat, pa, stat_misses, exp_misses);
    end
    access(1'b0, 32'h0, quiet, pa, flt);
  endtask

  task automatic test_read_only();
    int lat, wr0, txn0; logic [31:0] pa, rd; logic flt, got;
    mem_model[32'h0000_8024] = 32'h0006_0001;
    translate(32'h0000_9004, lat, pa, flt);
    exp_misses++;
    checks++;
    if (lat !== 3 || pa !== 32'h0006_0004 || flt !== 1'b0) begin
      errors++; $display("FAIL ro_xlate: lat %0d paddr %h fault %b, want 3 00060004 0", lat, pa, flt);
    end
    wr0 = n_wr; txn0 = n_txn;
    access(1'b1, 32'hBAD0_BAD0, got, rd, flt);
    checks++;
    if (got !== 1'b1 || flt !== 1'b1 || n_wr !== wr0 || n_txn !== txn0) begin
      errors++; $display("FAIL ro_write: done %b fault %b writes %0d txn %0d, want 1 1 %0d %0d", got, flt, n_wr, n_txn, wr0, txn0);
    end
  endtask

  task automatic test_replace_flush();
    int lat, bad; logic [31:0] pa, rd, va; logic flt, got;
    flush_tlb();
    bad = 0;
    for (int v = 16; v < 25; v++) begin
      mem_model[32'h0000_8000 + 32'(v) * 4] = {12'h000, 20'(v + 256)} << 12 | 32'h3;
      va = {20'(v), 12'h0A8};
      translate(va, lat, pa, flt);
      exp_misses++;
      if (lat !== 3 || pa !== {20'(v + 256), 12'h0A8} || flt !== 1'b0) bad++;
      access(1'b0, 32'h0, got, rd, flt);
    end
    checks++;
    if (bad !== 0 || stat_misses !== 16'(exp_misses)) begin
      errors++; $display("FAIL fill_nine: bad %0d misses %0d, want 0 %0d", bad, stat_misses, exp_misses);
    end
    translate(32'h0001_1000, lat, pa, flt);
    checks++;
    if (lat !== 2 || pa !== 32'h0011_1000) begin
      errors++; $display("FAIL second_kept: lat %0d paddr %h, want 2 00111000", lat, pa);
    end
    access(1'b0, 32'h0, got, rd, flt);
    translate(32'h0001_0000, lat, pa, flt);
    exp_misses++;
    checks++;
    if (lat !== 3 || pa !== 32'h0011_0000 || stat_misses !== 16'(exp_misses)) begin
      errors++; $display("FAIL first_evicted: lat %0d paddr %h misses %0d, want 3 00110000 %0d", lat, pa, stat_misses, exp_misses);
    end
    access(1'b0, 32'h0, got, rd, flt);
    flush_tlb();
    translate(32'h0001_2000, lat, pa, flt);
    exp_misses++;
    checks++;
    if (lat !== 3 || pa !== 32'h0011_2000 || stat_misses !== 16'(exp_misses)) begin
      errors++; $display("FAIL after_flush: lat %0d paddr %h misses %0d, want 3 00112000 %0d", lat, pa, stat_misses, exp_misses);
    end
    access(1'b0, 32'h0, got, rd, flt);
  endtask

  task automatic test_reset_mid_walk();
    int lat, wr0; logic [31:0] pa, rd; logic flt, got, seen;
    mem_stall = 1'b1;
    mem_model[32'h0000_8080] = 32'h0007_0003;
    wr0 = n_wr;
    @(negedge clk);
    dma.iommu_daddr = 32'h0002_0000;
    dma.iommu_translate_request = 1'b1;
    @(posedge clk);
    #1 dma.iommu_translate_request = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = mem.mem_req;
    end
    checks++;
    if (seen !== 1'b1) begin
      errors++; $display("FAIL walk_start: req %b want 1", seen);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (mem.mem_req !== 1'b0 || dma.iommu_paddr !== 32'h0 || dma.iommu_data_out !== 32'h0 ||
        dma.iommu_translation_done !== 1'b0 || stat_misses !== 16'h0) begin
      errors++; $display("FAIL mid_reset: req %b paddr %h data %h done %b misses %0d, want all 0",
                         mem.mem_req, dma.iommu_paddr, dma.iommu_data_out, dma.iommu_translation_done, stat_misses);
    end
    mem_stall = 1'b0;
    exp_misses = 0;
    @(negedge clk);
    reset_n = 1'b1;
    translate(32'h0000_3010, lat, pa, flt);
    exp_misses++;
    checks++;
    if (lat !== 3 || pa !== 32'h0005_0010 || flt !== 1'b0 || stat_misses !== 16'(exp_misses)) begin
      errors++; $display("FAIL post_reset: lat %0d paddr %h fault %b misses %0d, want 3 00050010 0 1", lat, pa, flt, stat_misses);
    end
    access(1'b0, 32'h0, got, rd, flt);
    checks++;
    if (got !== 1'b1 || rd !== 32'hCAFE_0001 || n_wr !== wr0) begin
      errors++; $display("FAIL post_reset_read: done %b data %h writes %0d, want 1 cafe0001 %0d", got, rd, n_wr, wr0);
    end
  endtask

  initial begin
    dma.iommu_daddr = 32'h0;
    dma.iommu_translate_request = 1'b0;
    dma.iommu_write_en = 1'b0;
    dma.iommu_write_data = 32'h0;
    mem.mem_ack = 1'b0;
    mem.mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk) reset_n = 1'b1;
    test_bypass();
    test_miss_hit();
    test_invalid_pte();
    test_read_only();
    test_replace_flush();
    test_reset_mid_walk();
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iommu_responder.md
Name: iommu_responder

Overview:
- Responder end of the DMA-to-IOMMU interface: accepts DMA virtual-address translate requests and answers with physical address or fault.
- Performs the follow-on data access (read or write) on behalf of the DMA master.
- Small fully-associative TLB backed by a single-level page-table walk.
- Sits between the DMA engine and system memory; page-table reads and data accesses share one memory port.

Parameters:
TLB_ENTRIES, 8, number of TLB entries (power of two, >=2)
PAGE_SHIFT, 12, page size 4 KiB; VPN = daddr[31:12], offset = daddr[11:0]

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
iommu_daddr  input  32  device virtual address
iommu_translate_request  input  1  level request from DMA, sampled only in IDLE
iommu_write_en  input  1  access direction, sampled only in ACCESS
iommu_write_data  input  32  write data, sampled only in ACCESS
iommu_paddr  output  32  translated physical address
iommu_data_out  output  32  read data from the access phase
iommu_translation_done  output  1  one-cycle completion pulse (translation or access)
iommu_fault  output  1  qualifies translation_done
cfg_pt_base  input  32  page-table base, word aligned
cfg_enable  input  1  0 = bypass (paddr = daddr, writable, no TLB, no walk)
tlb_flush  input  1  pulse; invalidates all TLB entries
mem_req  output  1  memory request, held until mem_ack
mem_we  output  1  1 = write
mem_addr  output  32  memory address
mem_wdata  output  32  memory write data
mem_rdata  input  32  memory read data, valid with mem_ack
mem_ack  input  1  one-cycle completion from memory
stat_misses  output  16  saturating TLB-miss counter

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; TLB valid bits cleared; round-robin pointer 0; stat_misses 0. Reset during any state aborts the operation; no partial write.
- PTE format: bit0 V (valid), bit1 W (writable), [31:12] PPN. PTE address = cfg_pt_base + (VPN << 2), 32-bit wrap.
- IDLE: on translate_request=1, latch daddr into vaddr_q and go to LOOKUP.
- LOOKUP:
  - Bypass (cfg_enable=0): paddr_q = vaddr_q, W=1, go to RESP.
  - TLB hit: paddr_q = {PPN, offset}, W from entry, go to RESP. Hit latency: done asserts 2 edges after the edge that sampled the request.
  - Miss: mem_req=1, mem_we=0, mem_addr = PTE address; stat_misses+1 (saturates at 0xFFFF); go to WALK.
- WALK: hold request until mem_ack.
  - V=1: install {VPN, PPN, W} at the round-robin entry, increment pointer mod TLB_ENTRIES, go to RESP.
  - V=0: mark fault, no install, go to RESP.
- RESP: translation_done=1 for exactly one cycle. iommu_paddr = paddr_q, or 0 on fault. fault=1 goes to IDLE; otherwise go to SETTLE.
- SETTLE: one idle cycle so the DMA can update write_en after observing done; go to ACCESS.
- ACCESS: sample write_en and write_data.
  - write_en=1 and W=0: done+fault pulse next cycle, no memory access, go to IDLE.
  - Otherwise: mem_req=1, mem_we=write_en, mem_addr=paddr_q, mem_wdata=write_data; go to MEM_WAIT.
- MEM_WAIT: on mem_ack, pulse done (fault=0); on reads, iommu_data_out = mem_rdata on the same edge; go to IDLE.
- translate_request is ignored outside IDLE. A request held high across the return to IDLE starts a new translation.
- tlb_flush clears all valid bits at the next edge; pointer is reset to 0. A flush on the same edge as a WALK install wins: the entry is not installed, but the translation is still returned.
- Duplicate VPN never installed: a walk occurs only on a miss and flush is the only invalidation, so lookups are at most one-hot.
- iommu_paddr and iommu_data_out hold their values until next overwritten.

Decomposition:
- Shared package iommu_pkg:
  - PAGE_SHIFT and PTE bit positions (PTE_V=0, PTE_W=1).
  - State enum: IDLE, LOOKUP, WALK, RESP, SETTLE, ACCESS, MEM_WAIT.
  - tlb_entry_t struct {valid, vpn[19:0], ppn[19:0], w}.
- Sub-module iommu_tlb: combinational CAM lookup (hit, ppn, w), install port, round-robin pointer, flush.

Test Plan:
1. Bypass: cfg_enable=0, request daddr 0x0000_1234 -> done at +2 with paddr 0x0000_1234, fault 0. Then write_en=0 -> mem read at 0x1234; mem_rdata 0xDEADBEEF returned on iommu_data_out with done pulse.
2. Miss then hit: pt_base 0x8000, daddr 0x0000_3010, PTE at 0x800C = 0x0005_0003 -> walk read 0x800C, paddr 0x0005_0010, stat_misses=1. Next request 0x3020 -> no mem walk, paddr 0x0005_0020, done at +2.
3. Invalid PTE 0x0000_0000 -> done with fault=1, paddr 0, no access phase, IDLE next cycle, TLB unchanged.
4. Read-only page: PTE 0x0006_0001, write_en=1 in ACCESS -> done+fault, mem_req never asserted with mem_we=1.
5. Replacement and flush: 9 distinct VPN misses with TLB_ENTRIES=8 -> first VPN evicted (re-walked). tlb_flush, then any earlier VPN -> walk again, stat_misses increments.
6. Reset mid-walk: reset_n low while in WALK -> all outputs 0 immediately, state IDLE. Next request after release completes normally.
